// File: rtl/mips_alu_top.sv
// mips_alu_top: registered 32-bit MIPS-style ALU with built-in ALU-control
// decode. The opcode/funct fields select an operation on A/B. The result and
// the zero flag are registered together, so branch logic downstream always
// sees a consistent pair one cycle after the operands were presented.
module mips_alu_top #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func_field,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // Internal ALU operation produced by the control decode
  typedef enum logic [3:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_SLT,
    OP_SLTU
  } alu_op_e;

  alu_op_e          alu_op;
  logic [WIDTH-1:0] next_result;
  logic             signed_lt;
  logic             unsigned_lt;

  // ALU control: map opcode (and funct for R-type) onto an ALU operation;
  // anything unrecognised becomes a NOP that yields zero
  always_comb begin
    alu_op = OP_NOP;
    unique case (opcode)
      6'h00: begin
        unique case (func_field)
          6'h20, 6'h21: alu_op = OP_ADD;
          6'h22, 6'h23: alu_op = OP_SUB;
          6'h24:        alu_op = OP_AND;
          6'h25:        alu_op = OP_OR;
          6'h26:        alu_op = OP_XOR;
          6'h27:        alu_op = OP_NOR;
          6'h2A:        alu_op = OP_SLT;
          6'h2B:        alu_op = OP_SLTU;
          default:      alu_op = OP_NOP;
        endcase
      end
      6'h23, 6'h2B, 6'h08, 6'h09: alu_op = OP_ADD;
      6'h04, 6'h05:               alu_op = OP_SUB;
      6'h0C:                      alu_op = OP_AND;
      6'h0D:                      alu_op = OP_OR;
      6'h0E:                      alu_op = OP_XOR;
      6'h0A:                      alu_op = OP_SLT;
      6'h0B:                      alu_op = OP_SLTU;
      default:                    alu_op = OP_NOP;
    endcase
  end

  // Datapath: compute the value that will be registered this cycle;
  // add/sub simply wrap, there is no overflow detection
  always_comb begin
    signed_lt   = $signed(A) < $signed(B);
    unsigned_lt = A < B;
    next_result = '0;
    unique case (alu_op)
      OP_ADD:  next_result = A + B;
      OP_SUB:  next_result = A - B;
      OP_AND:  next_result = A & B;
      OP_OR:   next_result = A | B;
      OP_XOR:  next_result = A ^ B;
      OP_NOR:  next_result = ~(A | B);
      OP_SLT:  next_result = {{(WIDTH-1){1'b0}}, signed_lt};
      OP_SLTU: next_result = {{(WIDTH-1){1'b0}}, unsigned_lt};
      default: next_result = '0;
    endcase
  end

  // Output register: zero is taken from the same value loaded into result
  // so the two can never disagree; reset overrides any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      zero   <= 1'b1;
    end else begin
      result <= next_result;
      zero   <= (next_result == '0);
    end
  end

endmodule

// File: tb/tb_mips_alu_top.sv
// tb_mips_alu_top: self-checking bench for mips_alu_top. Every driven
// operation pushes its expected result/zero pair onto a scoreboard queue,
// which is popped and compared once the registered output is available.
module tb_mips_alu_top;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic [5:0]       func_field;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic             zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] r;
    logic             z;
    logic [127:0]     nm;
  } exp_t;

  typedef struct {
    logic             rst;
    logic [5:0]       op;
    logic [5:0]       fn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] er;
    logic [127:0]     nm;
  } vec_t;

  exp_t sb[$];

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  mips_alu_top #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .func_field (func_field),
    .A          (A),
    .B          (B),
    .result     (result),
    .zero       (zero)
  );

  // Present one operation and record what the ALU must produce for it
  task automatic drive(input vec_t v);
    reset      = v.rst;
    opcode     = v.op;
    func_field = v.fn;
    A          = v.a;
    B          = v.b;
    sb.push_back('{r: v.er, z: (v.er == '0), nm: v.nm});
  endtask

  // Independent reference of the ALU behaviour, written from the opcode table
  function automatic logic [WIDTH-1:0] model(input logic [5:0] op, input logic [5:0] fn,
                                              input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [5:0] f;
    f = fn;
    if (op != 6'h00) begin
      case (op)
        6'h23, 6'h2B, 6'h08, 6'h09: f = 6'h20;
        6'h04, 6'h05:               f = 6'h22;
        6'h0C:                      f = 6'h24;
        6'h0D:                      f = 6'h25;
        6'h0E:                      f = 6'h26;
        6'h0A:                      f = 6'h2A;
        6'h0B:                      f = 6'h2B;
        default:                    f = 6'h3F;
      endcase
    end
    case (f)
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24:        return a & b;
      6'h25:        return a | b;
      6'h26:        return a ^ b;
      6'h27:        return ~(a | b);
      6'h2A:        return ($signed(a) < $signed(b)) ? 1 : 0;
      6'h2B:        return (a < b) ? 1 : 0;
      default:      return '0;
    endcase
  endfunction

  task automatic test_reset();
    vec_t v[2] = '{
      '{1'b1, 6'h00, 6'h20, 32'h2222, 32'h1111, 32'h0, "reset_edge1"},
      '{1'b1, 6'h00, 6'h20, 32'h2222, 32'h1111, 32'h0, "reset_edge2"}
    };
    exp_t e;
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (result !== e.r || zero !== e.z) begin
        errors++;
        $display("[TB] FAIL %0s: result=%h zero=%b expected result=%h zero=%b", e.nm, result, zero, e.r, e.z);
      end
    end
  endtask

  task automatic test_rtype();
    vec_t v[8] = '{
      '{1'b0, 6'h00, 6'h20, 32'h2222, 32'h1111, 32'h3333,     "add"},
      '{1'b0, 6'h00, 6'h24, 32'h2222, 32'h1111, 32'h0000,     "and"},
      '{1'b0, 6'h00, 6'h22, 32'h2222, 32'h1111, 32'h1111,     "sub"},
      '{1'b0, 6'h00, 6'h25, 32'h2222, 32'h1111, 32'h3333,     "or"},
      '{1'b0, 6'h00, 6'h26, 32'h2323, 32'h1111, 32'h3232,     "xor"},
      '{1'b0, 6'h00, 6'h27, 32'h2222, 32'h1111, 32'hFFFFCCCC, "nor"},
      '{1'b0, 6'h00, 6'h21, 32'h2222, 32'h1111, 32'h3333,     "addu"},
      '{1'b0, 6'h00, 6'h23, 32'h1111, 32'h2222, 32'hFFFFEEEF, "subu"}
    };
    exp_t e;
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (result !== e.r || zero !== e.z) begin
        errors++;
        $display("[TB] FAIL %0s: result=%h zero=%b expected result=%h zero=%b", e.nm, result, zero, e.r, e.z);
      end
    end
  endtask

  task automatic test_itype();
    vec_t v[9] = '{
      '{1'b0, 6'h23, 6'h00, 32'h2222, 32'h1111, 32'h3333, "lw"},
      '{1'b0, 6'h2B, 6'h22, 32'h2222, 32'h1111, 32'h3333, "sw_fn_ignored"},
      '{1'b0, 6'h08, 6'h27, 32'h0100, 32'h0023, 32'h0123, "addi"},
      '{1'b0, 6'h09, 6'h00, 32'h0100, 32'h0042, 32'h0142, "addiu"},
      '{1'b0, 6'h0C, 6'h25, 32'hF0F0, 32'h0FF0, 32'h00F0, "andi"},
      '{1'b0, 6'h0D, 6'h24, 32'hF0F0, 32'h0FF0, 32'hFFF0, "ori"},
      '{1'b0, 6'h0E, 6'h00, 32'hF0F0, 32'h0FF0, 32'hFF00, "xori"},
      '{1'b0, 6'h05, 6'h00, 32'h0009, 32'h0004, 32'h0005, "bne"},
      '{1'b0, 6'h0A, 6'h2B, 32'h0003, 32'h0007, 32'h0001, "slti"}
    };
    exp_t e;
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (result !== e.r || zero !== e.z) begin
        errors++;
        $display("[TB] FAIL %0s: result=%h zero=%b expected result=%h zero=%b", e.nm, result, zero, e.r, e.z);
      end
    end
  endtask

  task automatic test_branch_slt();
    vec_t v[8] = '{
      '{1'b0, 6'h04, 6'h00, 32'h5555,     32'h5555,     32'h0, "beq_equal"},
      '{1'b0, 6'h04, 6'h00, 32'h5556,     32'h5555,     32'h1, "beq_differ"},
      '{1'b0, 6'h00, 6'h2A, 32'h1111,     32'h2222,     32'h1, "slt_less"},
      '{1'b0, 6'h00, 6'h2A, 32'h2222,     32'h1111,     32'h0, "slt_greater"},
      '{1'b0, 6'h00, 6'h2A, 32'hFFFFFFFF, 32'h00000001, 32'h1, "slt_negative"},
      '{1'b0, 6'h00, 6'h2B, 32'hFFFFFFFF, 32'h00000001, 32'h0, "sltu_big"},
      '{1'b0, 6'h0B, 6'h00, 32'h00000001, 32'hFFFFFFFF, 32'h1, "sltiu_less"},
      '{1'b0, 6'h0A, 6'h00, 32'h00000001, 32'hFFFFFFFF, 32'h0, "slti_vs_neg"}
    };
    exp_t e;
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (result !== e.r || zero !== e.z) begin
        errors++;
        $display("[TB] FAIL %0s: result=%h zero=%b expected result=%h zero=%b", e.nm, result, zero, e.r, e.z);
      end
    end
  endtask

  task automatic test_edges();
    vec_t v[9] = '{
      '{1'b0, 6'h00, 6'h20, 32'hFFFFFFFF, 32'h1,    32'h0,        "add_wrap"},
      '{1'b0, 6'h00, 6'h27, 32'h0,        32'h0,    32'hFFFFFFFF, "nor_zero"},
      '{1'b0, 6'h00, 6'h22, 32'h0,        32'h1,    32'hFFFFFFFF, "sub_wrap"},
      '{1'b0, 6'h3F, 6'h20, 32'h2222,     32'h1111, 32'h0,        "bad_opcode"},
      '{1'b0, 6'h00, 6'h3F, 32'h2222,     32'h1111, 32'h0,        "bad_funct"},
      '{1'b0, 6'h00, 6'h20, 32'h2222,     32'h1111, 32'h3333,     "pre_reset_add"},
      '{1'b1, 6'h00, 6'h20, 32'h2222,     32'h1111, 32'h0,        "midstream_reset"},
      '{1'b0, 6'h00, 6'h25, 32'h8000,     32'h0001, 32'h8001,     "post_reset_or"},
      '{1'b0, 6'h00, 6'h20, 32'h80000000, 32'h80000000, 32'h0,    "add_msb_wrap"}
    };
    exp_t e;
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (result !== e.r || zero !== e.z) begin
        errors++;
        $display("[TB] FAIL %0s: result=%h zero=%b expected result=%h zero=%b", e.nm, result, zero, e.r, e.z);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[11] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B};
    logic [5:0] fns[10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    vec_t v;
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      v.rst = 1'b0;
      v.op  = ops[$urandom_range(0, 10)];
      v.fn  = (v.op == 6'h00) ? fns[$urandom_range(0, 9)] : 6'($urandom);
      v.a   = (i % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      v.b   = (i % 7 == 0) ? v.a : $urandom;
      v.er  = model(v.op, v.fn, v.a, v.b);
      v.nm  = "back_to_back";
      drive(v);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (result !== e.r || zero !== e.z) begin
        errors++;
        $display("[TB] FAIL %0s op=%h fn=%h: result=%h zero=%b expected result=%h zero=%b",
                 e.nm, v.op, v.fn, result, zero, e.r, e.z);
      end
    end
  endtask

  // Test sequence: tasks run back-to-back, one operation per clock
  initial begin
    reset      = 1'b1;
    opcode     = '0;
    func_field = '0;
    A          = '0;
    B          = '0;
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_itype();
    test_branch_slt();
    test_edges();
    test_back_to_back();
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: entries left=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends even if the sequence stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time=%0t limit=200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
